// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: bus between the instruction sequencer (master) and
// the single-bus CPU datapath / RAM side (slave).
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [31:0]     instr_in;
    logic [3:0]      flg_in;
    logic [PC_W-1:0] pc;
    logic            fetch;
    logic [31:0]     ir;
    logic            add_bus_sel;
    logic            ram_rw;
    logic            reg_we;
    logic            ldr_sel;
    logic            halted;

    modport master (
        input  run, instr_in, flg_in,
        output pc, fetch, ir, add_bus_sel, ram_rw, reg_we, ldr_sel, halted
    );

    modport slave (
        output run, instr_in, flg_in,
        input  pc, fetch, ir, add_bus_sel, ram_rw, reg_we, ldr_sel, halted
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/memory/writeback control
// FSM owning the program counter and instruction register.
// Optional feature macro: SEQ_BRANCH_EN -- enables B/BZ branching and the
// latched Z flag; without it opcodes 0xA/0xB behave as NOP.
module instr_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    instr_sequencer_if.master bus
);
    localparam logic [3:0] OP_LDR  = 4'h8;
    localparam logic [3:0] OP_STR  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;
`ifdef SEQ_BRANCH_EN
    localparam logic [3:0] OP_B    = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_boundary;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_fetch;
    logic            r_add_bus_sel;
    logic            r_ram_rw;
    logic            r_reg_we;
    logic            r_ldr_sel;
    logic            r_halted;

    logic [3:0]      w_op;
    logic            w_is_alu;
    logic            w_is_ldr;
    logic            w_is_str;
    logic            w_is_halt;
    logic            w_take_branch;
    logic [PC_W-1:0] w_target;

    assign w_op      = r_ir[27:24];
    assign w_is_alu  = ~w_op[3];
    assign w_is_ldr  = (w_op == OP_LDR);
    assign w_is_str  = (w_op == OP_STR);
    assign w_is_halt = (w_op == OP_HALT);
    assign w_target  = PC_W'(r_ir[7:0]);

`ifdef SEQ_BRANCH_EN
    logic r_z;
    logic w_unused_flags;

    assign w_take_branch  = (w_op == OP_B) | ((w_op == OP_BZ) & r_z);
    assign w_unused_flags = ^{bus.flg_in[3], bus.flg_in[1:0]};

    // Z flag captured from the ALU while an ALU op executes; BZ tests it later
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_z <= 1'b0;
        end else if (r_state == S_EXEC && w_is_alu) begin
            r_z <= bus.flg_in[2];
        end
    end
`else
    logic w_unused_flags;

    assign w_take_branch  = 1'b0;
    assign w_unused_flags = ^{bus.flg_in, w_target};
`endif

    // Next-state decode; run is consulted only when an instruction ends
    always_comb begin
        w_next     = r_state;
        w_boundary = bus.run ? S_FETCH : S_IDLE;
        case (r_state)
            S_IDLE:   if (bus.run) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_is_alu)                  w_next = S_WB;
                else if (w_is_ldr || w_is_str) w_next = S_MEM;
                else if (w_is_halt)            w_next = S_HALT;
                else                           w_next = w_boundary;
            end
            S_MEM:    w_next = w_is_ldr ? S_WB : w_boundary;
            S_WB:     w_next = w_boundary;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register plus strobes registered from the next state so every
    // output changes exactly with the state and never glitches
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_fetch       <= 1'b0;
            r_add_bus_sel <= 1'b0;
            r_ram_rw      <= 1'b0;
            r_reg_we      <= 1'b0;
            r_ldr_sel     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_fetch       <= (w_next == S_FETCH);
            r_add_bus_sel <= (w_next == S_MEM);
            r_ram_rw      <= (w_next == S_MEM) && w_is_str;
            r_reg_we      <= (w_next == S_WB);
            r_ldr_sel     <= (w_next == S_WB) && w_is_ldr;
            r_halted      <= (w_next == S_HALT);
        end
    end

    // PC/IR: latch the instruction and step the PC in FETCH, redirect in EXEC
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
        end else if (r_state == S_FETCH) begin
            r_ir <= bus.instr_in;
            r_pc <= r_pc + PC_W'(1);
        end else if (r_state == S_EXEC && w_take_branch) begin
            r_pc <= w_target;
        end
    end

    assign bus.pc          = r_pc;
    assign bus.ir          = r_ir;
    assign bus.fetch       = r_fetch;
    assign bus.add_bus_sel = r_add_bus_sel;
    assign bus.ram_rw      = r_ram_rw;
    assign bus.reg_we      = r_reg_we;
    assign bus.ldr_sel     = r_ldr_sel;
    assign bus.halted      = r_halted;
endmodule
